temp_sampler: RTL and testbench
===============================

# temp_sampler

Front-end conditioning stage directly upstream of the temperature-derivative estimator. It accepts raw ADC temperature codes, rejects open/short sensor codes, and boxcar-averages over 2^N_LOG samples. It converts the mean to signed Q7.0 with saturation. It drives the estimator's `T_cur`, a per-sample valid strobe, and the one-cycle `init` pulse that re-seeds the estimator after reset or a sensor fault.

## Interface
- `W_ADC`, 12: raw ADC code width.
- `N_LOG`, 2: log2 of the averaging window (window = 4 samples); legal range 0..4.
- `TIMEOUT`, 1000: cycles without `adc_valid` before a timeout fault is raised; used only when the timeout feature is enabled.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `adc_valid` in 1: one-cycle strobe; `adc_data` is valid in the same cycle.
- `adc_data` in W_ADC: raw unsigned code.
- `zero_code` in W_ADC: ADC code that corresponds to 0 °C.
- `gain_shift` in 4: arithmetic right shift applied after zero subtraction.
- `T_cur` out 8 signed: temperature, Q7.0.
- `t_valid` out 1: one-cycle strobe; a new `T_cur` is available.
- `init` out 1: one-cycle strobe; asserted together with the first `t_valid` after FILL completes.
- `fault` out 1: level signal, high while in FAULT.

## Operation
- States: FILL, RUN, FAULT. FAULT is entered from FILL or RUN.
- Reset state is FILL.
- Accepted sample: `adc_valid` is high and `adc_data` is neither 0 nor all-ones.
- Bad sample: `adc_valid` is high and `adc_data` is 0 or all-ones.
- FILL:
  - Each accepted sample is written into the circular buffer and added to the running sum.
  - The fill counter increments with each accepted sample.
  - On the 2^N_LOG-th accepted sample, move to RUN and schedule an output with `init` = 1.
- RUN:
  - Each accepted sample updates the sum as: sum = sum + new − oldest. The oldest entry is overwritten and the write pointer wraps modulo 2^N_LOG.
  - Each accepted sample schedules one output with `init` = 0.
- A bad sample in FILL or RUN:
  - Moves the state to FAULT.
  - Clears the sum, buffer, pointer and fill counter.
  - Is not scheduled for output.
- FAULT:
  - `fault` = 1.
  - Bad samples are ignored.
  - The first accepted sample moves the state to FILL and is counted as fill sample 1. `fault` drops in the same cycle the state changes.
- Conversion, computed from the updated sum:
  - mean = sum >> N_LOG.
  - d = signed(mean − zero_code), computed at W_ADC+1 bits.
  - t = d >>> gain_shift.
  - Saturate t to the range [−128, 127].
- An output already in flight in stage 2 when a bad sample arrives is still emitted, because it belongs to an earlier good sample.
- `T_cur` holds its last value whenever `t_valid` is low, including throughout FAULT.

## Timing
- Reset values: `T_cur` = 0, `t_valid` = 0, `init` = 0, `fault` = 0, state = FILL, sum = 0, counters = 0.
- Latency is 2 cycles: `adc_valid` in cycle n produces `t_valid` (and `init` when applicable) in cycle n+2.
  - Stage 1 registers the sum and the buffer.
  - Stage 2 registers `T_cur`.
- Back-to-back `adc_valid` on every cycle is supported at full throughput; there is no backpressure.
- `fault` rises in the cycle after the bad sample is seen.
- A synchronous reset mid-operation clears both pipeline stages; no `t_valid` is produced for samples in flight.
- `init` is never asserted without `t_valid`.

## Configuration
- `TEMP_SAMPLER_TIMEOUT_EN` defined:
  - An idle counter is cleared by every `adc_valid` and runs in FILL and RUN.
  - When the counter reaches TIMEOUT, the state moves to FAULT with the same clearing as a bad sample.
  - The counter is held at 0 while in FAULT.
- `TEMP_SAMPLER_TIMEOUT_EN` undefined:
  - No idle counter is built and the TIMEOUT parameter is unused.
  - FAULT is entered only on bad codes.

## Structure
- Package `temp_pkg` holds:
  - The state enum (FILL/RUN/FAULT).
  - The Q7.0 saturation limits TEMP_MAX = 127 and TEMP_MIN = −128.
  - The bad-code constants.
- Sub-module `boxcar_avg` holds the circular buffer, running sum, pointer and fill counter, and exposes a `clear` input. The top level holds the FSM, the conversion and the output registers.

## Test plan
- Reset, zero_code = 0x800, gain_shift = 4, N_LOG = 2; feed four samples of 0x900 -> 4th sample gives `t_valid` and `init` together 2 cycles later with `T_cur` = 16; a 5th sample of 0x900 gives `T_cur` = 16 with `init` = 0.
- Saturation: gain_shift = 0, samples of 0xFF0 -> `T_cur` = 127; samples of 0x100 with gain_shift = 4 -> `T_cur` = −112; samples of 0x001 with gain_shift = 0 -> `T_cur` = −128.
- In RUN, feed 0x000 -> `fault` = 1 the next cycle and no `t_valid` for that sample; then feed four samples of 0x880 -> `fault` = 0, `init` together with `t_valid`, `T_cur` = 8.
- Window averaging: after filling with 0x800, feed 0xC00 once (gain_shift = 4) -> `T_cur` = 16 (mean 0x900); feed 0xC00 three more times -> `T_cur` = 64.
- With `TEMP_SAMPLER_TIMEOUT_EN` defined and TIMEOUT = 20: reach RUN, then stop `adc_valid` -> `fault` rises 20 cycles after the last strobe; without the macro, `fault` stays 0.
- Assert `rst_n` = 0 in the cycle after an accepted `adc_valid` in RUN -> no `t_valid` follows, all outputs are 0, and the state is FILL.

Source files
------------

// File: rtl/temp_sampler_pkg.sv
// temp_pkg: shared types and constants for the temp_sampler block.
//   state_t          : FILL / RUN / FAULT controller states
//   TEMP_MAX/MIN     : Q7.0 saturation limits of T_cur
//   is_bad_code()    : open (all-zero) / short (all-ones) sensor code detector
package temp_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int TEMP_MAX = 127;
  localparam int TEMP_MIN = -128;

  // Open-sensor and shorted-sensor codes, expressed for any ADC width up to 32.
  localparam logic [31:0] BAD_CODE_OPEN = 32'd0;

  function automatic logic is_bad_code(input logic [31:0] code, input int w);
    logic [31:0] all_ones;
    all_ones = (32'd1 << w) - 32'd1;
    return (code == BAD_CODE_OPEN) || (code == all_ones);
  endfunction

endpackage

// File: rtl/temp_sampler_if.sv
// temp_sampler_if: ADC-side input strobe and estimator-side outputs.
//   adc_valid/adc_data   : raw ADC sample strobe and code
//   zero_code/gain_shift : static conversion settings
//   T_cur/t_valid/init   : Q7.0 temperature, its strobe, estimator re-seed pulse
//   fault                : high while the sensor is considered faulty
//   master : drives the ADC side (testbench / upstream)
//   slave  : the temp_sampler block
interface temp_sampler_if #(
  parameter int W_ADC = 12
);
  logic               adc_valid;
  logic [W_ADC-1:0]   adc_data;
  logic [W_ADC-1:0]   zero_code;
  logic [3:0]         gain_shift;
  logic signed [7:0]  T_cur;
  logic               t_valid;
  logic               init;
  logic               fault;

  modport master (
    output adc_valid, adc_data, zero_code, gain_shift,
    input  T_cur, t_valid, init, fault
  );

  modport slave (
    input  adc_valid, adc_data, zero_code, gain_shift,
    output T_cur, t_valid, init, fault
  );
endinterface

// File: rtl/boxcar_avg.sv
// boxcar_avg: circular buffer of the last 2^N_LOG accepted samples plus the
// running sum over them.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : empties buffer, sum, pointer and fill counter
//   wr_en/din  : writes one sample (overwrites the oldest entry)
//   sum        : registered sum of the buffer contents
//   fill_cnt   : number of samples written since the last clear (saturates)
module boxcar_avg #(
  parameter int W_ADC = 12,
  parameter int N_LOG = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [W_ADC-1:0]       din,
  output logic [W_ADC+N_LOG-1:0] sum,
  output logic [N_LOG:0]         fill_cnt
);
  localparam int WIN   = 1 << N_LOG;
  localparam int SUM_W = W_ADC + N_LOG;
  localparam int PTR_W = (N_LOG > 0) ? N_LOG : 1;

  logic [W_ADC-1:0] buf_q [WIN];
  logic [PTR_W-1:0] ptr;

  // Empty slots hold zero, so the same sum + new - oldest update works while
  // filling and while running.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sum      <= '0;
      ptr      <= '0;
      fill_cnt <= '0;
      for (int i = 0; i < WIN; i++) buf_q[i] <= '0;
    end else if (wr_en) begin
      sum        <= sum + SUM_W'(din) - SUM_W'(buf_q[ptr]);
      buf_q[ptr] <= din;
      ptr        <= (ptr == PTR_W'(WIN - 1)) ? '0 : ptr + 1'b1;
      if (fill_cnt != (N_LOG + 1)'(WIN)) fill_cnt <= fill_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/temp_sampler.sv
// temp_sampler: ADC front end for the temperature-derivative estimator.
// Rejects open/short codes, boxcar-averages 2^N_LOG samples, converts the mean
// to saturated signed Q7.0 and issues t_valid / init / fault.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : temp_sampler_if.slave (ADC strobe in, T_cur/t_valid/init/fault out)
// Latency: adc_valid in cycle n -> t_valid in cycle n+2.
// Optional: define TEMP_SAMPLER_TIMEOUT_EN to fault after TIMEOUT idle cycles
// (fault is visible TIMEOUT cycles after the last strobe; TIMEOUT >= 2).
module temp_sampler
  import temp_pkg::*;
#(
  parameter int W_ADC   = 12,
  parameter int N_LOG   = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  temp_sampler_if.slave bus
);
  localparam int WIN   = 1 << N_LOG;
  localparam int SUM_W = W_ADC + N_LOG;
  localparam logic signed [W_ADC:0] SAT_HI = TEMP_MAX;
  localparam logic signed [W_ADC:0] SAT_LO = TEMP_MIN;

  function automatic logic signed [7:0] sat_q7(input logic signed [W_ADC:0] v);
    if (v > SAT_HI)      return 8'sd127;
    else if (v < SAT_LO) return -8'sd128;
    else                 return v[7:0];
  endfunction

  state_t            state, state_nxt;
  logic              accept, bad, last_fill;
  logic              buf_clr, buf_wr, sched, sched_init;
  logic              timeout_hit;
  logic [SUM_W-1:0]  sum_p1;
  logic [N_LOG:0]    fill_cnt;
  logic              vld_p1, init_p1;
  logic [W_ADC-1:0]  mean_p1;
  logic signed [W_ADC:0] diff_p1, shf_p1;

  assign bad       = bus.adc_valid && is_bad_code(32'(bus.adc_data), W_ADC);
  assign accept    = bus.adc_valid && !bad;
  assign last_fill = (fill_cnt == (N_LOG + 1)'(WIN - 1));

`ifdef TEMP_SAMPLER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt;

  // Counter reads k-1 in the k-th cycle after the last strobe, so the
  // transition fires one cycle ahead and fault shows TIMEOUT cycles after it.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.adc_valid || state == FAULT) idle_cnt <= '0;
    else                                           idle_cnt <= idle_cnt + 1'b1;
  end
  assign timeout_hit = !bus.adc_valid && (state != FAULT) &&
                       (idle_cnt == IDLE_W'(TIMEOUT - 2));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    buf_clr    = 1'b0;
    buf_wr     = 1'b0;
    sched      = 1'b0;
    sched_init = 1'b0;
    case (state)
      FILL, RUN: begin
        if (bad || timeout_hit) begin
          state_nxt = FAULT;
          buf_clr   = 1'b1;
        end else if (accept) begin
          buf_wr = 1'b1;
          if (state == RUN) begin
            sched = 1'b1;
          end else if (last_fill) begin
            state_nxt  = RUN;
            sched      = 1'b1;
            sched_init = 1'b1;
          end
        end
      end
      FAULT: begin
        // Buffer is already empty here, so this sample becomes fill sample 1.
        if (accept) begin
          buf_wr = 1'b1;
          if (last_fill) begin
            state_nxt  = RUN;
            sched      = 1'b1;
            sched_init = 1'b1;
          end else begin
            state_nxt = FILL;
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Stage 1: running sum and buffer, output scheduling
  boxcar_avg #(
    .W_ADC (W_ADC),
    .N_LOG (N_LOG)
  ) u_boxcar (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (buf_clr),
    .wr_en    (buf_wr),
    .din      (bus.adc_data),
    .sum      (sum_p1),
    .fill_cnt (fill_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      init_p1 <= 1'b0;
    end else begin
      vld_p1  <= sched;
      init_p1 <= sched_init;
    end
  end

  assign mean_p1 = sum_p1[SUM_W-1:N_LOG];
  assign diff_p1 = $signed({1'b0, mean_p1}) - $signed({1'b0, bus.zero_code});
  assign shf_p1  = diff_p1 >>> bus.gain_shift;

  // Stage 2: converted temperature and strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.T_cur   <= '0;
      bus.t_valid <= 1'b0;
      bus.init    <= 1'b0;
    end else begin
      bus.t_valid <= vld_p1;
      bus.init    <= init_p1;
      if (vld_p1) bus.T_cur <= sat_q7(shf_p1);
    end
  end

  assign bus.fault = (state == FAULT);

endmodule

// File: tb/tb_temp_sampler.sv
module tb_temp_sampler;

  typedef struct {
    logic signed [7:0] t;
    logic              init;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t exp_q [$];

  always #5 clk = ~clk;

  temp_sampler_if #(.W_ADC(12)) bus ();

  temp_sampler #(
    .W_ADC   (12),
    .N_LOG   (2),
    .TIMEOUT (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: every t_valid pops one expected entry.
  always @(negedge clk) begin
    if (bus.t_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_t_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("T_cur", int'(bus.T_cur), int'(e.t));
        check("init", int'(bus.init), int'(e.init));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [11:0] code);
    bus.adc_valid = 1'b1;
    bus.adc_data  = code;
    tick(1);
    bus.adc_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [11:0] code, input int t, input logic ini);
    exp_t e;
    e.t    = 8'(t);
    e.init = ini;
    exp_q.push_back(e);
    send(code);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Three silent fill samples then one that produces the init output.
  task automatic fill4(input logic [11:0] code, input int t);
    repeat (3) send(code);
    send_exp(code, t, 1'b1);
  endtask

  task automatic drain();
    int budget;
    budget = 10;
    tick(3);
    while (exp_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    bus.adc_valid  = 1'b0;
    bus.adc_data   = '0;
    bus.zero_code  = 12'h800;
    bus.gain_shift = 4'd4;
    tick(3);
    check("rst_T_cur", int'(bus.T_cur), 0);
    check("rst_t_valid", int'(bus.t_valid), 0);
    check("rst_init", int'(bus.init), 0);
    check("rst_fault", int'(bus.fault), 0);
    rst_n = 1'b1;
    tick(1);

    // Basic fill, then one running sample
    fill4(12'h900, 16);
    send_exp(12'h900, 16, 1'b0);
    drain();

    // Saturation cases, each from a fresh window
    bus.gain_shift = 4'd0;
    do_reset();
    fill4(12'hFF0, 127);
    drain();
    bus.gain_shift = 4'd4;
    do_reset();
    fill4(12'h100, -112);
    drain();
    bus.gain_shift = 4'd0;
    do_reset();
    fill4(12'h001, -128);
    drain();

    // Fault on open code, recovery with a fresh fill
    bus.gain_shift = 4'd4;
    do_reset();
    fill4(12'h900, 16);
    drain();
    send(12'h000);
    check("fault_rise", int'(bus.fault), 1);
    tick(2);
    check("fault_no_output_T_hold", int'(bus.T_cur), 16);
    send(12'hFFF);
    check("fault_bad_ignored", int'(bus.fault), 1);
    send(12'h880);
    check("fault_drop", int'(bus.fault), 0);
    repeat (2) send(12'h880);
    send_exp(12'h880, 8, 1'b1);
    drain();

    // In-flight good sample survives a following short code
    send_exp(12'h880, 8, 1'b0);
    send(12'hFFF);
    check("fault_after_inflight", int'(bus.fault), 1);
    drain();
    fill4(12'h900, 16);
    drain();

    // Window averaging
    do_reset();
    fill4(12'h800, 0);
    send_exp(12'hC00, 16, 1'b0);
    send_exp(12'hC00, 32, 1'b0);
    send_exp(12'hC00, 48, 1'b0);
    send_exp(12'hC00, 64, 1'b0);
    drain();

    // Idle timeout
    do_reset();
    fill4(12'h900, 16);
`ifdef TEMP_SAMPLER_TIMEOUT_EN
    tick(18);
    check("timeout_not_yet", int'(bus.fault), 0);
    tick(1);
    check("timeout_fault", int'(bus.fault), 1);
`else
    tick(30);
    check("no_timeout", int'(bus.fault), 0);
`endif
    drain();

    // Reset with a sample in flight
    do_reset();
    fill4(12'h900, 16);
    drain();
    send(12'h900);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    check("midrst_T_cur", int'(bus.T_cur), 0);
    check("midrst_t_valid", int'(bus.t_valid), 0);
    check("midrst_fault", int'(bus.fault), 0);
    fill4(12'h880, 8);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
